writeback_pipe: RTL
===================

# writeback_pipe

Parametrised writeback stage that tracks each issued instruction's opecode, destination register and write-enable through a configurable number of pipeline slots, so they match the execute unit's latency. At the head slot it selects the writeback data source (load-forward path for loads, execute result otherwise) and drives the register-file write port. It also reports read-after-write hazards for the decode stage's source registers against every in-flight entry. It sits between execute and the register file. With DEPTH=1 it reproduces the single-slot writeback stage, except that write-enable is gated by valid.

## Interface
Parameters (the LEN_* and OPECODE_* values come from defs_insn.v):
- LEN_OPECODE, from defs_insn.v: opecode width.
- LEN_REGNO, from defs_insn.v: register-number width.
- LEN_REG, from defs_insn.v: register data width.
- OPECODE_LD, from defs_insn.v: load opecode; selects data_o_forward.
- OPECODE_CMP, from defs_insn.v: reset opecode (no-writeback filler).
- DEPTH, default 2: slots between issue and writeback; legal range 1..8.
- NUM_SRC, default 2: number of source operands checked for hazards; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-high.
- valid_i  in  1  upstream instruction valid.
- valid_o  out  1  head slot valid.
- stall_i  in  1  downstream stall; freezes all slots.
- stall_o  out  1  stall to upstream, = valid_o & stall_i.
- opecode  in  LEN_OPECODE  opecode of the issuing instruction.
- rd_regno  in  LEN_REGNO  destination register of the issuing instruction.
- is_wb  in  1  issuing instruction writes rd.
- data_o  in  LEN_REG  execute result, aligned to the head slot.
- data_o_forward  in  LEN_REG  load data, aligned to the head slot.
- src_regno  in  NUM_SRC*LEN_REGNO  decode source registers; operand i occupies bits [i*LEN_REGNO +: LEN_REGNO].
- hazard  out  NUM_SRC  bit i set when operand i matches a pending write.
- wb_regno  out  LEN_REGNO  head destination register.
- wb_data  out  LEN_REG  head write data.
- do_wb  out  1  register-file write enable.

## Operation
- Slots 0..DEPTH-1 form a shift register. Each slot holds {valid, opecode, rd_regno, wb}. Slot 0 captures the inputs; slot DEPTH-1 is the head.
- On posedge with stall_i=0:
  - slot 0 captures {valid_i, opecode, rd_regno, is_wb};
  - slot k captures slot k-1 for k≥1.
- On posedge with stall_i=1: all slots hold. Inputs presented that cycle are not captured; upstream must hold them.
- valid_o = head.valid.
- wb_regno = head.rd_regno.
- wb_data = data_o_forward when head.opecode == OPECODE_LD, otherwise data_o. The select is purely combinational from the head slot.
- do_wb = head.valid & head.wb. While stalled, do_wb stays high and the write repeats each cycle. The register file treats this as idempotent.
- hazard[i] = OR over all slots k of (slot k.valid & slot k.wb & slot k.rd_regno == src_i).
  - Combinational, and includes the head slot.
  - Excludes the instruction currently on the inputs; decode handles that case itself.
- An entry with valid=0 never asserts do_wb or hazard, whatever its wb or rd_regno contents.

## Timing
- Latency: an instruction captured at edge t reaches the head after DEPTH non-stalled edges. do_wb is visible in the cycle after the DEPTH-th such edge.
- Throughput: one instruction per non-stalled cycle.
- rst asserted, asynchronously, no clock required:
  - every slot: valid=0, wb=0, opecode=OPECODE_CMP, rd_regno=0;
  - outputs: valid_o=0, do_wb=0, stall_o=0, hazard=0, wb_regno=0, wb_data=data_o.
- rst asserted mid-operation: all in-flight entries are discarded. No do_wb pulse may occur on or after the rst edge.
- rst deasserted: the first capture happens on the next posedge with stall_i=0.
- stall_i together with an empty head: stall_o=0, but slots still freeze. stall_i is global.
- A bubble (valid_i=0) shifts through like an instruction and produces no write.
- Two in-flight writes to the same rd: hazard stays asserted until both have left the head.

## Structure
- defs_insn.v (shared): LEN_OPECODE, LEN_REGNO, LEN_REG, OPECODE_LD, OPECODE_CMP. No new package content.
- Sub-module wb_slot holds one slot register with async reset and hold-on-stall. It is instantiated DEPTH times in a generate loop.
- Hazard compare: a generate loop over NUM_SRC × DEPTH, reduced with OR.
- Head mux and do_wb gating live in the top level.

## Test plan
- Latency, DEPTH=3: issue ADD rd=5, is_wb=1, data_o=0x1234 aligned at the head → do_wb=1, wb_regno=5, wb_data=0x1234 exactly 3 cycles after capture; hazard[0]=1 for src0=5 during those 3 cycles.
- Load select: issue OPECODE_LD rd=7, data_o=0xAAAA, data_o_forward=0x5555 → wb_data=0x5555 at the head.
- Stall: assert stall_i for 4 cycles while the head is valid → stall_o=1 throughout; head and other slots are unchanged; do_wb is held; resume gives no lost or duplicated slot shift.
- Reset mid-flight: fill all slots with is_wb=1, then pulse rst between clock edges → valid_o=0, do_wb=0, hazard=0 immediately; no write follows.
- Bubbles and invalid entries: valid_i=0 with is_wb=1, rd=3 → do_wb is never asserted and hazard for src=3 stays 0.
- DEPTH=1, NUM_SRC=1 build: back-to-back writes to rd=2 then rd=4 → do_wb asserted on consecutive cycles with wb_regno 2 then 4.

Source files
------------

// File: rtl/writeback_pipe_pkg.sv
// Shared instruction-format constants for the writeback stage (opecode, register
// number and register data widths, plus the opecodes the stage cares about).
package writeback_pipe_pkg;

    localparam int DEFS_LEN_OPECODE = 6;
    localparam int DEFS_LEN_REGNO   = 5;
    localparam int DEFS_LEN_REG     = 32;

    localparam logic [DEFS_LEN_OPECODE-1:0] DEFS_OPECODE_LD  = 6'h10;
    // Compare never writes back, which makes it the natural empty-slot filler.
    localparam logic [DEFS_LEN_OPECODE-1:0] DEFS_OPECODE_CMP = 6'h0A;

endpackage

// File: rtl/writeback_pipe_slot.sv
// One pipeline slot of the writeback stage: {valid, opecode, rd_regno, wb},
// loaded from its predecessor unless the stage is stalled.
module wb_slot
    import writeback_pipe_pkg::*;
#(
    parameter int                     LEN_OPECODE = DEFS_LEN_OPECODE,
    parameter int                     LEN_REGNO   = DEFS_LEN_REGNO,
    parameter logic [LEN_OPECODE-1:0] RST_OPECODE = DEFS_OPECODE_CMP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   valid_i,
    input  logic [LEN_OPECODE-1:0] opecode_i,
    input  logic [LEN_REGNO-1:0]   rd_regno_i,
    input  logic                   wb_i,
    output logic                   valid_o,
    output logic [LEN_OPECODE-1:0] opecode_o,
    output logic [LEN_REGNO-1:0]   rd_regno_o,
    output logic                   wb_o
);

    logic                   valid_q,    valid_d;
    logic [LEN_OPECODE-1:0] opecode_q,  opecode_d;
    logic [LEN_REGNO-1:0]   rd_regno_q, rd_regno_d;
    logic                   wb_q,       wb_d;

    always_comb begin
        valid_d    = valid_q;
        opecode_d  = opecode_q;
        rd_regno_d = rd_regno_q;
        wb_d       = wb_q;
        if (!stall_i) begin
            valid_d    = valid_i;
            opecode_d  = opecode_i;
            rd_regno_d = rd_regno_i;
            wb_d       = wb_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            opecode_q  <= RST_OPECODE;
            rd_regno_q <= '0;
            wb_q       <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            opecode_q  <= opecode_d;
            rd_regno_q <= rd_regno_d;
            wb_q       <= wb_d;
        end
    end

    assign valid_o    = valid_q;
    assign opecode_o  = opecode_q;
    assign rd_regno_o = rd_regno_q;
    assign wb_o       = wb_q;

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: delays issued instructions by DEPTH slots to meet the execute
// result, drives the register-file write port and flags RAW hazards for decode.
module writeback_pipe
    import writeback_pipe_pkg::*;
#(
    parameter int                     LEN_OPECODE = DEFS_LEN_OPECODE,
    parameter int                     LEN_REGNO   = DEFS_LEN_REGNO,
    parameter int                     LEN_REG     = DEFS_LEN_REG,
    parameter logic [LEN_OPECODE-1:0] OPECODE_LD  = DEFS_OPECODE_LD,
    parameter logic [LEN_OPECODE-1:0] OPECODE_CMP = DEFS_OPECODE_CMP,
    parameter int                     DEPTH       = 2,
    parameter int                     NUM_SRC     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    output logic                           valid_o,
    input  logic                           stall_i,
    output logic                           stall_o,
    input  logic [LEN_OPECODE-1:0]         opecode,
    input  logic [LEN_REGNO-1:0]           rd_regno,
    input  logic                           is_wb,
    input  logic [LEN_REG-1:0]             data_o,
    input  logic [LEN_REG-1:0]             data_o_forward,
    input  logic [NUM_SRC*LEN_REGNO-1:0]   src_regno,
    output logic [NUM_SRC-1:0]             hazard,
    output logic [LEN_REGNO-1:0]           wb_regno,
    output logic [LEN_REG-1:0]             wb_data,
    output logic                           do_wb
);

    localparam int HEAD = DEPTH - 1;

    logic [DEPTH-1:0]       slot_valid;
    logic [DEPTH-1:0]       slot_wb;
    logic [LEN_OPECODE-1:0] slot_op [DEPTH];
    logic [LEN_REGNO-1:0]   slot_rd [DEPTH];

    genvar k, i;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_slot
            if (k == 0) begin : g_first
                wb_slot #(
                    .LEN_OPECODE (LEN_OPECODE),
                    .LEN_REGNO   (LEN_REGNO),
                    .RST_OPECODE (OPECODE_CMP)
                ) u_slot (
                    .clk        (clk),
                    .rst        (rst),
                    .stall_i    (stall_i),
                    .valid_i    (valid_i),
                    .opecode_i  (opecode),
                    .rd_regno_i (rd_regno),
                    .wb_i       (is_wb),
                    .valid_o    (slot_valid[k]),
                    .opecode_o  (slot_op[k]),
                    .rd_regno_o (slot_rd[k]),
                    .wb_o       (slot_wb[k])
                );
            end else begin : g_next
                wb_slot #(
                    .LEN_OPECODE (LEN_OPECODE),
                    .LEN_REGNO   (LEN_REGNO),
                    .RST_OPECODE (OPECODE_CMP)
                ) u_slot (
                    .clk        (clk),
                    .rst        (rst),
                    .stall_i    (stall_i),
                    .valid_i    (slot_valid[k-1]),
                    .opecode_i  (slot_op[k-1]),
                    .rd_regno_i (slot_rd[k-1]),
                    .wb_i       (slot_wb[k-1]),
                    .valid_o    (slot_valid[k]),
                    .opecode_o  (slot_op[k]),
                    .rd_regno_o (slot_rd[k]),
                    .wb_o       (slot_wb[k])
                );
            end
        end

        // Every in-flight entry, head included, counts as a pending write.
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            logic [DEPTH-1:0] match;
            for (k = 0; k < DEPTH; k++) begin : g_cmp
                assign match[k] = slot_valid[k] & slot_wb[k]
                                & (slot_rd[k] == src_regno[i*LEN_REGNO +: LEN_REGNO]);
            end
            assign hazard[i] = |match;
        end
    endgenerate

    assign valid_o  = slot_valid[HEAD];
    assign stall_o  = slot_valid[HEAD] & stall_i;
    assign wb_regno = slot_rd[HEAD];
    assign wb_data  = (slot_op[HEAD] == OPECODE_LD) ? data_o_forward : data_o;
    // A stalled head keeps writing the same value; the register file absorbs repeats.
    assign do_wb    = slot_valid[HEAD] & slot_wb[HEAD];

endmodule
